barrel_thread_scheduler: RTL and testbench
==========================================

# barrel_thread_scheduler

Round-robin thread issue stage for the barrel-threaded RISC-V core. Each cycle it selects the next thread slot, decides whether that thread may issue, and presents the thread ID and PC to fetch. It keeps one PC register per thread, updated from writeback, plus an in-flight flag per thread. Issue slots whose thread is busy or inactive become bubbles, so thread count and pipeline depth may be chosen independently.

## Interface
Parameters:
- NUM_THREADS, default `NUM_THREADS (32): hardware threads; need not be a power of two; min 1.
- PC_WIDTH, default ADDR_WIDTH: PC width (word address).
- RESET_PC, default STARTUP_ADDR: every thread's PC after reset.
- RESET_ACTIVE_MASK, default all ones: active mask after reset; used only with THREAD_CTL_EN.
- TID_W, default max(1, $clog2(NUM_THREADS)): thread-ID width; derived, not overridden.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run_i  in  1  global enable; 0 freezes the rotation and forces bubbles.
- issue_valid_o  out  1  registered; the slot carries a real instruction.
- issue_tid_o  out  TID_W  registered; slot thread ID, driven on bubbles too.
- issue_pc_o  out  PC_WIDTH  registered; PC to fetch.
- wb_valid_i  in  1  writeback of one thread's next PC.
- wb_tid_i  in  TID_W  writeback thread.
- wb_next_pc_i  in  PC_WIDTH  resolved next PC.
- ctl_valid_i  in  1  control request (THREAD_CTL_EN only).
- ctl_op_i  in  2  thread_ctl_op_t: NOP / START / STOP.
- ctl_tid_i  in  TID_W  target thread.
- ctl_pc_i  in  PC_WIDTH  start PC.
- ctl_ack_o  out  1  one-cycle pulse; request accepted.
- ctl_err_o  out  1  one-cycle pulse; request rejected.
- active_mask_o  out  NUM_THREADS  current active threads.

## Operation
- rr_tid counter: increments each cycle while run_i=1; goes NUM_THREADS-1 -> 0; holds while run_i=0.
- Bypass hit: wb_valid_i && wb_tid_i==rr_tid.
- Issue condition: run_i && active[rr_tid] && (!inflight[rr_tid] || bypass hit).
- On issue: issue_pc_o gets wb_next_pc_i on a bypass hit, otherwise pc[rr_tid]. inflight[rr_tid] is set.
- Writeback: pc[wb_tid] <= wb_next_pc_i and inflight[wb_tid] cleared, unless the same cycle re-sets it through issue.
- wb_tid_i >= NUM_THREADS is ignored.
- START on an inactive thread: pc <= ctl_pc_i, active set, ack. START on an active thread: rejected, err, no state change.
- STOP: active cleared, ack. An in-flight instruction still writes back normally. STOP on an inactive thread still acks.
- NOP, or ctl_tid_i >= NUM_THREADS: err.
- Same cycle, same thread, START and wb: START's PC wins; wb still clears inflight.
- STOP and issue of the same thread in the same cycle: the issue happens; the stop applies from the next slot.

## Timing
- Issue outputs are registered: one cycle from rr_tid selection to output.
- With NUM_THREADS >= round-trip issue-to-writeback latency: full throughput, no bubbles from inflight.
- Shorter thread counts insert bubbles automatically.
- ctl_ack_o / ctl_err_o assert the cycle after ctl_valid_i and are never both high.
- Reset, immediately and asynchronously: issue_valid_o=0, issue_tid_o=0, issue_pc_o=0, rr_tid=0, inflight all 0, every pc=RESET_PC, ctl_ack_o=0, ctl_err_o=0, active_mask_o=RESET_ACTIVE_MASK.
- Reset mid-operation discards all in-flight tracking. The downstream pipeline shares the reset.

## Configuration
- THREAD_CTL_EN defined: ctl_* ports, the active register and START/STOP behave as above.
- THREAD_CTL_EN undefined:
  - ctl_* inputs are ignored; ctl_ack_o and ctl_err_o are tied to 0.
  - active_mask_o is all ones and every thread is permanently active.
  - The issue condition reduces to run_i && (!inflight || bypass hit).

## Structure
- riscv_pkg additions: thread_ctl_op_t enum (CTL_NOP=0, CTL_START=1, CTL_STOP=2) and a tid_width(n) function.
- Sub-module thread_pc_file: NUM_THREADS x PC_WIDTH flop array.
  - One asynchronous read port.
  - Two write ports; the ctl port has priority over the wb port.
  - Reset value RESET_PC.
- Elaboration assertion: NUM_THREADS >= 1.

## Test plan
- Reset, NUM_THREADS=4, RESET_PC=0x10, run_i=1, wb fed back 3 cycles after each issue with pc+1 -> tids 0,1,2,3,0...; thread 0 reissues at 0x11; no bubbles.
- NUM_THREADS=3 with a 5-cycle writeback loop -> each slot alternates issue/bubble as inflight blocks it; the PC sequence per thread is monotonic with no skips.
- NUM_THREADS=5 -> tid wraps 4->0; run_i low for 3 cycles -> valid=0 and tid frozen, then resumes at the next tid.
- THREAD_CTL_EN, RESET_ACTIVE_MASK=4'b0001:
  - START tid 2 at 0x40 -> ack next cycle; tid 2 issues 0x40 in its next slot.
  - A second START of tid 2 -> err.
- STOP tid 1 while in flight -> tid 1's later slots are bubbles; its wb still updates the PC; a subsequent START overrides that PC.
- Async reset asserted mid-run -> all outputs take their reset values the same cycle; after release the rotation restarts at tid 0 from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions used by the barrel-thread issue stage.
package riscv_pkg;

    localparam int unsigned ADDR_WIDTH = 30;
    localparam logic [ADDR_WIDTH-1:0] STARTUP_ADDR = '0;

    typedef enum logic [1:0] {
        CTL_NOP   = 2'd0,
        CTL_START = 2'd1,
        CTL_STOP  = 2'd2
    } thread_ctl_op_t;

    // Thread-ID width; a single thread still needs a 1-bit ID.
    function automatic int unsigned tid_width(input int unsigned n);
        return (n <= 1) ? 1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/thread_pc_file.sv
// Per-thread PC storage: one asynchronous read port, two write ports (ctl beats wb).
module thread_pc_file
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 32,
    parameter int unsigned PC_WIDTH = ADDR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(STARTUP_ADDR),
    localparam int unsigned TID_W = tid_width(NUM_THREADS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TID_W-1:0]    rd_tid,
    output logic [PC_WIDTH-1:0] rd_pc_c,
    input  logic                ctl_we,
    input  logic [TID_W-1:0]    ctl_tid,
    input  logic [PC_WIDTH-1:0] ctl_pc,
    input  logic                wb_we,
    input  logic [TID_W-1:0]    wb_tid,
    input  logic [PC_WIDTH-1:0] wb_pc
);

    logic [PC_WIDTH-1:0] pc_q [NUM_THREADS];

    // IDs outside the array match no entry, so out-of-range writes are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_PC;
            end
        end else begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                if (ctl_we && (ctl_tid == TID_W'(t))) begin
                    pc_q[t] <= ctl_pc;
                end else if (wb_we && (wb_tid == TID_W'(t))) begin
                    pc_q[t] <= wb_pc;
                end
            end
        end
    end

    always_comb begin
        rd_pc_c = pc_q[0];
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (rd_tid == TID_W'(t)) begin
                rd_pc_c = pc_q[t];
            end
        end
    end

endmodule

// File: rtl/barrel_thread_scheduler.sv
// Round-robin barrel-thread issue stage with per-thread PC and in-flight tracking.
// Define THREAD_CTL_EN to enable START/STOP thread control and the active mask.
`ifndef NUM_THREADS
`define NUM_THREADS 32
`endif

module barrel_thread_scheduler
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_THREADS = `NUM_THREADS,
    parameter int unsigned PC_WIDTH = ADDR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(STARTUP_ADDR),
    parameter logic [NUM_THREADS-1:0] RESET_ACTIVE_MASK = '1,
    localparam int unsigned TID_W = tid_width(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_i,
    output logic                   issue_valid_o,
    output logic [TID_W-1:0]       issue_tid_o,
    output logic [PC_WIDTH-1:0]    issue_pc_o,
    input  logic                   wb_valid_i,
    input  logic [TID_W-1:0]       wb_tid_i,
    input  logic [PC_WIDTH-1:0]    wb_next_pc_i,
    input  logic                   ctl_valid_i,
    input  thread_ctl_op_t         ctl_op_i,
    input  logic [TID_W-1:0]       ctl_tid_i,
    input  logic [PC_WIDTH-1:0]    ctl_pc_i,
    output logic                   ctl_ack_o,
    output logic                   ctl_err_o,
    output logic [NUM_THREADS-1:0] active_mask_o
);

    localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);

    if (NUM_THREADS < 1) begin : g_bad_num_threads
        $error("barrel_thread_scheduler: NUM_THREADS must be at least 1");
    end

    logic [TID_W-1:0]       rr_tid_q, rr_tid_d;
    logic [NUM_THREADS-1:0] inflight_q, inflight_d;
    logic [NUM_THREADS-1:0] active_w;
    logic                   slot_busy_c, slot_active_c, bypass_c, issue_c;
    logic [PC_WIDTH-1:0]    rd_pc_c, issue_pc_c;
    logic                   start_we_c;

    thread_pc_file #(
        .NUM_THREADS (NUM_THREADS),
        .PC_WIDTH    (PC_WIDTH),
        .RESET_PC    (RESET_PC)
    ) u_pc_file (
        .clk     (clk),
        .reset   (reset),
        .rd_tid  (rr_tid_q),
        .rd_pc_c (rd_pc_c),
        .ctl_we  (start_we_c),
        .ctl_tid (ctl_tid_i),
        .ctl_pc  (ctl_pc_i),
        .wb_we   (wb_valid_i),
        .wb_tid  (wb_tid_i),
        .wb_pc   (wb_next_pc_i)
    );

    // Slot decision; a same-cycle writeback to the slot's thread is forwarded.
    always_comb begin
        slot_busy_c   = 1'b0;
        slot_active_c = 1'b0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (rr_tid_q == TID_W'(t)) begin
                slot_busy_c   = inflight_q[t];
                slot_active_c = active_w[t];
            end
        end
        bypass_c   = wb_valid_i && (wb_tid_i == rr_tid_q);
        issue_c    = run_i && slot_active_c && (!slot_busy_c || bypass_c);
        issue_pc_c = bypass_c ? wb_next_pc_i : rd_pc_c;

        rr_tid_d = rr_tid_q;
        if (run_i) begin
            rr_tid_d = (rr_tid_q == LAST_TID) ? '0 : rr_tid_q + TID_W'(1);
        end

        // Issue re-sets the flag after writeback clears it.
        inflight_d = inflight_q;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (wb_valid_i && (wb_tid_i == TID_W'(t))) begin
                inflight_d[t] = 1'b0;
            end
            if (issue_c && (rr_tid_q == TID_W'(t))) begin
                inflight_d[t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_tid_q      <= '0;
            inflight_q    <= '0;
            issue_valid_o <= 1'b0;
            issue_tid_o   <= '0;
            issue_pc_o    <= '0;
        end else begin
            rr_tid_q      <= rr_tid_d;
            inflight_q    <= inflight_d;
            issue_valid_o <= issue_c;
            issue_tid_o   <= rr_tid_q;
            issue_pc_o    <= issue_pc_c;
        end
    end

`ifdef THREAD_CTL_EN
    logic [NUM_THREADS-1:0] active_q, active_d;
    logic                   ack_d, err_d, ctl_tid_ok_c, ctl_tid_active_c;

    // START/STOP decode; STOP only affects slots from the next cycle on.
    always_comb begin
        active_d         = active_q;
        ack_d            = 1'b0;
        err_d            = 1'b0;
        start_we_c       = 1'b0;
        ctl_tid_ok_c     = 32'(ctl_tid_i) < NUM_THREADS;
        ctl_tid_active_c = 1'b0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (ctl_tid_i == TID_W'(t)) begin
                ctl_tid_active_c = active_q[t];
            end
        end
        if (ctl_valid_i) begin
            if (!ctl_tid_ok_c) begin
                err_d = 1'b1;
            end else begin
                case (ctl_op_i)
                    CTL_START: begin
                        if (ctl_tid_active_c) begin
                            err_d = 1'b1;
                        end else begin
                            ack_d      = 1'b1;
                            start_we_c = 1'b1;
                            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                                if (ctl_tid_i == TID_W'(t)) active_d[t] = 1'b1;
                            end
                        end
                    end
                    CTL_STOP: begin
                        ack_d = 1'b1;
                        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                            if (ctl_tid_i == TID_W'(t)) active_d[t] = 1'b0;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q  <= RESET_ACTIVE_MASK;
            ctl_ack_o <= 1'b0;
            ctl_err_o <= 1'b0;
        end else begin
            active_q  <= active_d;
            ctl_ack_o <= ack_d;
            ctl_err_o <= err_d;
        end
    end

    assign active_w      = active_q;
    assign active_mask_o = active_q;
`else
    // Every thread is permanently active; control inputs are sunk.
    localparam logic [NUM_THREADS-1:0] reset_mask_unused = RESET_ACTIVE_MASK;
    logic ctl_unused;

    assign ctl_unused    = ^{ctl_valid_i, ctl_op_i, ctl_tid_i, ctl_pc_i};
    assign start_we_c    = 1'b0;
    assign active_w      = '1;
    assign active_mask_o = '1;
    assign ctl_ack_o     = 1'b0;
    assign ctl_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_thread_scheduler.sv
// Scoreboard bench for barrel_thread_scheduler: a thread-level model predicts every slot.
module tb_barrel_thread_scheduler;
    import riscv_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned PW = 16;
    localparam int unsigned TW = 3;
    localparam logic [PW-1:0] RST_PC = 16'h0010;
    localparam logic [N-1:0]  RST_MASK = 5'b00001;

    typedef struct {
        logic          v;
        logic [TW-1:0] tid;
        logic [PW-1:0] pc;
        logic          ack;
        logic          err;
        logic [N-1:0]  mask;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run_i = 1'b0;
    logic wb_valid = 1'b0;
    logic [TW-1:0] wb_tid = '0;
    logic [PW-1:0] wb_next_pc = '0;
    logic ctl_valid = 1'b0;
    thread_ctl_op_t ctl_op = CTL_NOP;
    logic [TW-1:0] ctl_tid = '0;
    logic [PW-1:0] ctl_pc = '0;
    logic issue_valid, ctl_ack, ctl_err;
    logic [TW-1:0] issue_tid;
    logic [PW-1:0] issue_pc;
    logic [N-1:0] active_mask;

    int vectors = 0;
    int fails = 0;

    // Thread-level reference state
    logic [PW-1:0] m_pc [N];
    bit            m_busy [N];
    bit            m_act [N];
    int            m_rr;
    int            cyc = 0;
    bit            s_v [64];
    int            s_tid [64];
    logic [PW-1:0] s_pc [64];
    int            lat_min = 3, lat_max = 3;
    bit            spur_en = 1'b0;
    exp_t          exp_q [$];

    barrel_thread_scheduler #(
        .NUM_THREADS       (N),
        .PC_WIDTH          (PW),
        .RESET_PC          (RST_PC),
        .RESET_ACTIVE_MASK (RST_MASK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run_i         (run_i),
        .issue_valid_o (issue_valid),
        .issue_tid_o   (issue_tid),
        .issue_pc_o    (issue_pc),
        .wb_valid_i    (wb_valid),
        .wb_tid_i      (wb_tid),
        .wb_next_pc_i  (wb_next_pc),
        .ctl_valid_i   (ctl_valid),
        .ctl_op_i      (ctl_op),
        .ctl_tid_i     (ctl_tid),
        .ctl_pc_i      (ctl_pc),
        .ctl_ack_o     (ctl_ack),
        .ctl_err_o     (ctl_err),
        .active_mask_o (active_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        for (int t = 0; t < N; t++) m[t] = m_act[t];
        return m;
    endfunction

    function automatic logic [N-1:0] reset_mask();
        logic [N-1:0] mk;
`ifdef THREAD_CTL_EN
        mk = RST_MASK;
`else
        mk = '1;
`endif
        return mk;
    endfunction

    task automatic model_reset();
        logic [N-1:0] mk;
        mk = reset_mask();
        for (int t = 0; t < N; t++) begin
            m_pc[t] = RST_PC;
            m_busy[t] = 1'b0;
            m_act[t] = mk[t];
        end
        for (int i = 0; i < 64; i++) s_v[i] = 1'b0;
        m_rr = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_tid", 32'(issue_tid), 32'd0);
        chk("rst_pc", 32'(issue_pc), 32'd0);
        chk("rst_ack", 32'(ctl_ack), 32'd0);
        chk("rst_err", 32'(ctl_err), 32'd0);
        chk("rst_mask", 32'(active_mask), 32'(reset_mask()));
    endtask

    // Book the writeback of an issued instruction on the first free future cycle.
    task automatic schedule_wb(input int tid, input logic [PW-1:0] pc);
        int d;
        d = $urandom_range(lat_max, lat_min);
        while (s_v[(cyc + d) % 64]) d++;
        s_v[(cyc + d) % 64] = 1'b1;
        s_tid[(cyc + d) % 64] = tid;
        s_pc[(cyc + d) % 64] = ($urandom_range(0, 7) == 0) ? PW'($urandom) : PW'(pc + 16'd1);
    endtask

    // Called at a negedge: drive one cycle, predict its slot, return at the next negedge.
    task automatic step(input bit run, input bit cv, input int op, input int ct, input logic [PW-1:0] cp);
        int slot;
        bit hit, iss;
        exp_t e;
        slot = cyc % 64;
        if (s_v[slot]) begin
            wb_valid = 1'b1;
            wb_tid = TW'(s_tid[slot]);
            wb_next_pc = s_pc[slot];
            s_v[slot] = 1'b0;
        end else if (spur_en && $urandom_range(0, 9) == 0) begin
            wb_valid = 1'b1;
            wb_tid = TW'($urandom_range(0, 7));
            wb_next_pc = PW'($urandom);
        end else begin
            wb_valid = 1'b0;
            wb_tid = TW'($urandom);
            wb_next_pc = PW'($urandom);
        end
        run_i = run;
        ctl_valid = cv;
        ctl_op = thread_ctl_op_t'(2'(op));
        ctl_tid = TW'(ct);
        ctl_pc = cp;
        @(posedge clk);

        hit = wb_valid && (int'(wb_tid) == m_rr);
        iss = run && m_act[m_rr] && (!m_busy[m_rr] || hit);
        e.v = iss;
        e.tid = TW'(m_rr);
        e.pc = hit ? wb_next_pc : m_pc[m_rr];
        if (wb_valid && int'(wb_tid) < N) begin
            m_pc[wb_tid] = wb_next_pc;
            m_busy[wb_tid] = 1'b0;
        end
        if (iss) begin
            m_busy[m_rr] = 1'b1;
            schedule_wb(m_rr, e.pc);
        end
        e.ack = 1'b0;
        e.err = 1'b0;
`ifdef THREAD_CTL_EN
        if (cv) begin
            if (ct >= N || op == 0 || op == 3) e.err = 1'b1;
            else if (op == 1) begin
                if (m_act[ct]) e.err = 1'b1;
                else begin
                    e.ack = 1'b1;
                    m_act[ct] = 1'b1;
                    m_pc[ct] = cp;
                end
            end else begin
                e.ack = 1'b1;
                m_act[ct] = 1'b0;
            end
        end
`endif
        e.mask = model_mask();
        if (run) m_rr = (m_rr + 1) % N;
        cyc++;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, '0);
    endtask

    // Called at a negedge: async reset between edges, checked before any clock edge.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        run_i = 1'b0;
        wb_valid = 1'b0;
        ctl_valid = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one prediction per clocked slot
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_valid", 32'(issue_valid), 32'(e.v));
                chk("issue_tid", 32'(issue_tid), 32'(e.tid));
                if (e.v) chk("issue_pc", 32'(issue_pc), 32'(e.pc));
                chk("ctl_ack", 32'(ctl_ack), 32'(e.ack));
                chk("ctl_err", 32'(ctl_err), 32'(e.err));
                chk("active_mask", 32'(active_mask), 32'(e.mask));
            end
        end
    end

    initial begin
        int r, op;
        model_reset();
        #3;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed: thread control, freeze, boundary requests
        step(1'b1, 1'b1, 1, 2, 16'h0040);
        step(1'b1, 1'b1, 1, 2, 16'h0077);
        step(1'b1, 1'b1, 1, 1, 16'h0020);
        idle(6);
        step(1'b1, 1'b1, 2, 1, '0);
        idle(10);
        step(1'b1, 1'b1, 1, 1, 16'h0080);
        idle(8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, '0);
        idle(5);
        step(1'b1, 1'b1, 0, 0, '0);
        step(1'b1, 1'b1, 1, 6, 16'h0123);
        step(1'b1, 1'b1, 2, 4, '0);
        step(1'b1, 1'b1, 3, 0, '0);
        step(1'b1, 1'b1, 2, 4, '0);
        step(1'b1, 1'b1, 2, 7, '0);
        idle(5);

        // Randomized traffic with variable writeback latency
        lat_min = 1;
        lat_max = 9;
        spur_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 7);
            op = (r < 4) ? 1 : (r < 6) ? 2 : (r == 6) ? 0 : 3;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, op,
                 $urandom_range(0, 7), PW'($urandom));
        end

        mid_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 7);
            op = (r < 4) ? 1 : (r < 6) ? 2 : (r == 6) ? 0 : 3;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, op,
                 $urandom_range(0, 7), PW'($urandom));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
